fpu_adder_avalon_queue: RTL and testbench

//  Avalon-MM slave front end for the single-precision `adder` core (stb/ack handshake), with queuing.

---
 rtl/fpu_adder_avalon_queue_if.sv | 14 +
 rtl/fpu_adder_avalon_queue.sv | 188 ++++++++++++++++++
 tb/tb_fpu_adder_avalon_queue.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_adder_avalon_queue_if.sv
// Avalon-MM slave bus bundle for the queued FPU adder front end.
interface fpu_adder_avalon_queue_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] address;
    logic [31:0]       writedata;
    logic              write;
    logic              read;
    logic [31:0]       readdata;
    logic              waitrequest;

    modport master (output address, writedata, write, read, input readdata, waitrequest);
    modport slave  (input address, writedata, write, read, output readdata, waitrequest);
endinterface

// File: rtl/fpu_adder_avalon_queue.sv
// Avalon-MM front end that queues operand pairs to an stb/ack float adder core and queues its sums.
// Optional feature macro: RESULT_IRQ_EN (result-count threshold interrupt and IRQ_THRESH register).
module fpu_adder_avalon_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    fpu_adder_avalon_queue_if.slave bus,
    output logic        irq,
    output logic        core_rst,
    output logic [31:0] core_a,
    output logic        core_a_stb,
    input  logic        core_a_ack,
    output logic [31:0] core_b,
    output logic        core_b_stb,
    input  logic        core_b_ack,
    input  logic [31:0] core_z,
    input  logic        core_z_stb,
    output logic        core_z_ack
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, WAIT_Z} state_t;
    state_t state_reg, state_next;

    logic [31:0]      op_a_mem [DEPTH];
    logic [31:0]      op_b_mem [DEPTH];
    logic [31:0]      res_mem  [DEPTH];
    logic [PTR_W-1:0] op_wr_ptr_reg, op_rd_ptr_reg, res_wr_ptr_reg, res_rd_ptr_reg;
    logic [CNT_W-1:0] op_count_reg, res_count_reg;
    logic [31:0]      staging_a_reg, eng_a_reg, eng_b_reg, readdata_reg;
    logic             underflow_reg, overflow_reg, clr_pulse_reg;
    logic [31:0]      thresh_rd, status;

    logic sel_opa, sel_opb, sel_result, sel_status, sel_control, sel_thresh;
    logic op_empty, op_full, res_empty, res_full, busy;
    logic clear, clr_sticky, op_push, op_pop, res_push, res_pop;

    assign sel_opa     = bus.address == ADDR_W'(0);
    assign sel_opb     = bus.address == ADDR_W'(1);
    assign sel_result  = bus.address == ADDR_W'(2);
    assign sel_status  = bus.address == ADDR_W'(3);
    assign sel_control = bus.address == ADDR_W'(4);
    assign sel_thresh  = bus.address == ADDR_W'(5);

    assign op_empty  = op_count_reg == '0;
    assign op_full   = op_count_reg == FULL_CNT;
    assign res_empty = res_count_reg == '0;
    assign res_full  = res_count_reg == FULL_CNT;
    assign busy      = state_reg != IDLE;

    // Flags are from registered counts only, so a full operand FIFO stalls even if the engine pops now.
    assign bus.waitrequest = bus.write & sel_opb & op_full;
    assign bus.readdata    = readdata_reg;

    assign clear      = bus.write & sel_control & bus.writedata[0];
    assign clr_sticky = bus.write & sel_control & bus.writedata[1];
    assign op_push    = bus.write & sel_opb & ~op_full & ~clear;
    assign op_pop     = (state_reg == IDLE) & ~op_empty & ~res_full & ~clear;
    assign res_push   = core_z_ack & core_z_stb;
    assign res_pop    = bus.read & sel_result & ~res_empty & ~clear;

    assign status = {8'd0, 8'(op_count_reg), 8'(res_count_reg), 1'b0, overflow_reg,
                     underflow_reg, busy, res_full, res_empty, op_full, op_empty};

    assign core_rst = ~reset_n | clr_pulse_reg;
    assign core_a   = eng_a_reg;
    assign core_b   = eng_b_reg;

    always_comb begin
        state_next = state_reg;
        core_a_stb = 1'b0;
        core_b_stb = 1'b0;
        core_z_ack = 1'b0;
        case (state_reg)
            IDLE:   if (op_pop) state_next = LOAD_A;
            LOAD_A: begin
                core_a_stb = 1'b1;
                if (core_a_ack) state_next = LOAD_B;
            end
            LOAD_B: begin
                core_b_stb = 1'b1;
                if (core_b_ack) state_next = WAIT_Z;
            end
            WAIT_Z: begin
                core_z_ack = 1'b1;
                if (core_z_stb) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
            core_a_stb = 1'b0;
            core_b_stb = 1'b0;
            core_z_ack = 1'b0;
        end
    end

    // Storage without reset so the FIFO arrays map onto block RAM.
    always_ff @(posedge clk) begin
        if (op_push) begin
            op_a_mem[op_wr_ptr_reg] <= staging_a_reg;
            op_b_mem[op_wr_ptr_reg] <= bus.writedata;
        end
        if (op_pop) begin
            eng_a_reg <= op_a_mem[op_rd_ptr_reg];
            eng_b_reg <= op_b_mem[op_rd_ptr_reg];
        end
        if (res_push) res_mem[res_wr_ptr_reg] <= core_z;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            op_wr_ptr_reg  <= '0;
            op_rd_ptr_reg  <= '0;
            res_wr_ptr_reg <= '0;
            res_rd_ptr_reg <= '0;
            op_count_reg   <= '0;
            res_count_reg  <= '0;
            staging_a_reg  <= '0;
            readdata_reg   <= '0;
            underflow_reg  <= 1'b0;
            overflow_reg   <= 1'b0;
            clr_pulse_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            clr_pulse_reg <= clear;
            if (bus.write && sel_opa) staging_a_reg <= bus.writedata;

            if (clear) begin
                op_wr_ptr_reg  <= '0;
                op_rd_ptr_reg  <= '0;
                res_wr_ptr_reg <= '0;
                res_rd_ptr_reg <= '0;
                op_count_reg   <= '0;
                res_count_reg  <= '0;
            end else begin
                if (op_push)  op_wr_ptr_reg  <= op_wr_ptr_reg + PTR_W'(1);
                if (op_pop)   op_rd_ptr_reg  <= op_rd_ptr_reg + PTR_W'(1);
                if (res_push) res_wr_ptr_reg <= res_wr_ptr_reg + PTR_W'(1);
                if (res_pop)  res_rd_ptr_reg <= res_rd_ptr_reg + PTR_W'(1);
                op_count_reg  <= op_count_reg + CNT_W'(op_push) - CNT_W'(op_pop);
                res_count_reg <= res_count_reg + CNT_W'(res_push) - CNT_W'(res_pop);
            end

            if (clr_sticky) begin
                underflow_reg <= 1'b0;
                overflow_reg  <= 1'b0;
            end else begin
                if (bus.read && sel_result && res_empty) underflow_reg <= 1'b1;
                if (bus.waitrequest) overflow_reg <= 1'b1;
            end

            if (bus.read) begin
                if (sel_result)      readdata_reg <= res_empty ? 32'd0 : res_mem[res_rd_ptr_reg];
                else if (sel_status) readdata_reg <= status;
                else if (sel_thresh) readdata_reg <= thresh_rd;
                else                 readdata_reg <= 32'd0;
            end
        end
    end

`ifdef RESULT_IRQ_EN
    logic [7:0] irq_thresh_reg;
    logic       irq_reg;

    // Compares the registered count, so irq trails count changes by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_thresh_reg <= '0;
            irq_reg        <= 1'b0;
        end else begin
            if (bus.write && sel_thresh) irq_thresh_reg <= bus.writedata[7:0];
            irq_reg <= (8'(res_count_reg) >= irq_thresh_reg) && (irq_thresh_reg != 8'd0);
        end
    end

    assign irq       = irq_reg;
    assign thresh_rd = {24'd0, irq_thresh_reg};
`else
    assign irq       = 1'b0;
    assign thresh_rd = 32'd0;
`endif
endmodule

// File: tb/tb_fpu_adder_avalon_queue.sv
// Randomized self-checking bench: bus master, behavioural adder core, and a queue-based result model.
module tb_fpu_adder_avalon_queue;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fpu_adder_avalon_queue_if #(.ADDR_W(3)) av ();

    logic        irq, core_rst;
    logic [31:0] core_a, core_b, core_z;
    logic        core_a_stb, core_a_ack, core_b_stb, core_b_ack, core_z_stb, core_z_ack;

    fpu_adder_avalon_queue #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (av),
        .irq        (irq),
        .core_rst   (core_rst),
        .core_a     (core_a),
        .core_a_stb (core_a_stb),
        .core_a_ack (core_a_ack),
        .core_b     (core_b),
        .core_b_stb (core_b_stb),
        .core_b_ack (core_b_ack),
        .core_z     (core_z),
        .core_z_stb (core_z_stb),
        .core_z_ack (core_z_ack)
    );

    int checks = 0;
    int failures = 0;
    int unsigned exp_q[$];
    int unsigned last_a = 0;

    // Integer-valued single-precision encode/decode (values kept below 2^23).
    function automatic logic [31:0] to_f32(input int unsigned v);
        int p;
        logic [31:0] r;
        if (v == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 32; i++) if (v[i]) p = i;
        r[31]    = 1'b0;
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'(v << (23 - p));
        return r;
    endfunction

    function automatic int unsigned from_f32(input logic [31:0] f);
        int e;
        int unsigned m;
        if (f == 32'd0) return 0;
        e = int'(f[30:23]) - 127;
        m = {9'd1, f[22:0]};
        return m >> (23 - e);
    endfunction

    // Behavioural adder core with stb/ack handshakes and a random compute delay.
    logic hold_a = 1'b0, hold_b = 1'b0, hold_z = 1'b0;
    int cm_state = 0;
    int cm_cnt = 0;
    logic [31:0] cm_a = '0, cm_b = '0, cm_z = '0;

    assign core_a_ack = (cm_state == 0) && !hold_a;
    assign core_b_ack = (cm_state == 1) && !hold_b;
    assign core_z_stb = (cm_state == 3);
    assign core_z     = cm_z;

    always @(posedge clk) begin
        if (core_rst) begin
            cm_state <= 0;
        end else begin
            case (cm_state)
                0: if (core_a_stb && core_a_ack) begin cm_a <= core_a; cm_state <= 1; end
                1: if (core_b_stb && core_b_ack) begin
                       cm_b <= core_b;
                       cm_cnt <= int'($urandom_range(1, 4));
                       cm_state <= 2;
                   end
                2: if (!hold_z) begin
                       if (cm_cnt == 0) begin
                           cm_z <= to_f32(from_f32(cm_a) + from_f32(cm_b));
                           cm_state <= 3;
                       end else cm_cnt <= cm_cnt - 1;
                   end
                default: if (core_z_ack) cm_state <= 0;
            endcase
        end
    end

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        av.address = a; av.writedata = d; av.write = 1'b1;
        #1;
        n = 0;
        while (av.waitrequest && n < 2000) begin @(negedge clk); #1; n++; end
        if (av.waitrequest) begin
            checks++; failures++;
            $display("FAIL write_timeout addr=%0d waitrequest=1 required 0", a);
        end
        @(posedge clk); #1;
        av.write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        av.address = a; av.read = 1'b1;
        @(posedge clk); #1;
        av.read = 1'b0;
        d = av.readdata;
    endtask

    task automatic push_pair(input int unsigned a, input int unsigned b);
        bus_write(3'd0, to_f32(a));
        bus_write(3'd1, to_f32(b));
        last_a = a;
        exp_q.push_back(a + b);
    endtask

    task automatic wait_res_count(input int n);
        logic [31:0] st;
        int tries = 0;
        bus_read(3'd3, st);
        while (int'(st[15:8]) < n && tries < 500) begin bus_read(3'd3, st); tries++; end
        if (int'(st[15:8]) < n) begin
            checks++; failures++;
            $display("FAIL wait_res_count got=%0d required>=%0d", st[15:8], n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] st;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1; #1;
        checks++;
        if ({av.readdata, av.waitrequest, irq} !== 34'd0) begin
            failures++; $display("FAIL reset_outputs got=%h/%b/%b required 0/0/0", av.readdata, av.waitrequest, irq);
        end
        checks++;
        if ({core_a_stb, core_b_stb, core_z_ack, core_rst} !== 4'b0000) begin
            failures++; $display("FAIL reset_core_hs got=%b required 0000", {core_a_stb, core_b_stb, core_z_ack, core_rst});
        end
        bus_read(3'd3, st);
        checks++;
        if (st !== 32'h0000_0005) begin failures++; $display("FAIL reset_status got=%h required 00000005", st); end
    endtask

    task automatic test_single_add();
        logic [31:0] d;
        bus_write(3'd0, 32'h3F80_0000);
        bus_write(3'd1, 32'h4000_0000);
        wait_res_count(1);
        bus_read(3'd2, d);
        checks++;
        if (d !== 32'h4040_0000) begin failures++; $display("FAIL single_add got=%h required 40400000", d); end
        bus_read(3'd3, d);
        checks++;
        if (d[2] !== 1'b1) begin failures++; $display("FAIL single_res_empty got=%b required 1", d[2]); end
    endtask

    task automatic test_burst();
        logic [31:0] d;
        for (int k = 0; k < 8; k++) push_pair(k, 1);
        wait_res_count(8);
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h0000_0809) begin failures++; $display("FAIL burst_status got=%h required 00000809", d); end
        for (int k = 0; k < 8; k++) begin
            bus_read(3'd2, d);
            checks++;
            if (d !== to_f32(exp_q.pop_front())) begin
                failures++; $display("FAIL burst_result idx=%0d got=%h required %h", k, d, to_f32(k + 1));
            end
        end
        bus_read(3'd3, d);
        checks++;
        if (d[2] !== 1'b1) begin failures++; $display("FAIL burst_res_empty got=%b required 1", d[2]); end
    endtask

    task automatic test_random();
        logic [31:0] d;
        int n;
        int unsigned e;
        for (int r = 0; r < 5; r++) begin
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++) push_pair($urandom_range(0, 1 << 20), $urandom_range(0, 1 << 20));
            wait_res_count(n);
            for (int i = 0; i < n; i++) begin
                bus_read(3'd2, d);
                e = exp_q.pop_front();
                checks++;
                if (d !== to_f32(e)) begin failures++; $display("FAIL random_result got=%h required %h", d, to_f32(e)); end
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        logic [31:0] d;
        int n;
        int unsigned a, b, e;
        hold_a = 1'b1;
        for (int k = 0; k < 9; k++) push_pair($urandom_range(0, 1 << 20), $urandom_range(0, 1 << 20));
        bus_read(3'd3, d);
        checks++;
        if ({d[23:16], d[4], d[1]} !== {8'd8, 1'b1, 1'b1}) begin
            failures++; $display("FAIL stall_full_status got=%h required op_count=8 busy=1 op_full=1", d);
        end
        a = $urandom_range(0, 1 << 20);
        b = $urandom_range(0, 1 << 20);
        bus_write(3'd0, to_f32(a));
        @(negedge clk);
        av.address = 3'd1; av.writedata = to_f32(b); av.write = 1'b1;
        #1;
        checks++;
        if (av.waitrequest !== 1'b1) begin failures++; $display("FAIL stall_wait_first got=%b required 1", av.waitrequest); end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (av.waitrequest !== 1'b1) begin failures++; $display("FAIL stall_wait_held got=%b required 1", av.waitrequest); end
        hold_a = 1'b0;
        n = 0;
        while (av.waitrequest && n < 500) begin @(negedge clk); #1; n++; end
        checks++;
        if (av.waitrequest !== 1'b0) begin failures++; $display("FAIL stall_release got=%b required 0", av.waitrequest); end
        @(posedge clk); #1;
        av.write = 1'b0;
        last_a = a;
        exp_q.push_back(a + b);
        bus_read(3'd3, d);
        checks++;
        if ({d[23:16], d[6]} !== {8'd8, 1'b1}) begin
            failures++; $display("FAIL stall_after_status got=%h required op_count=8 overflow=1", d);
        end
        for (int i = 0; i < 10; i++) begin
            wait_res_count(1);
            bus_read(3'd2, d);
            e = exp_q.pop_front();
            checks++;
            if (d !== to_f32(e)) begin failures++; $display("FAIL stall_result idx=%0d got=%h required %h", i, d, to_f32(e)); end
        end
    endtask

    task automatic test_underflow_sticky();
        logic [31:0] d;
        bus_read(3'd2, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL underflow_data got=%h required 0", d); end
        bus_read(3'd3, d);
        checks++;
        if ({d[23:8], d[5]} !== {16'd0, 1'b1}) begin failures++; $display("FAIL underflow_sticky got=%h required counts 0 bit5=1", d); end
        bus_write(3'd4, 32'h2);
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h0000_0005) begin failures++; $display("FAIL sticky_clear got=%h required 00000005", d); end
    endtask

    task automatic test_clear();
        logic [31:0] d;
        int n;
        int unsigned b;
        hold_z = 1'b1;
        for (int k = 0; k < 3; k++) push_pair($urandom_range(1, 1 << 20), $urandom_range(0, 1 << 20));
        n = 0;
        while (cm_state != 2 && n < 200) begin @(negedge clk); n++; end
        bus_read(3'd3, d);
        checks++;
        if (d[4] !== 1'b1) begin failures++; $display("FAIL clear_busy_before got=%b required 1", d[4]); end
        bus_write(3'd4, 32'h1);
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h0000_0005) begin failures++; $display("FAIL clear_status got=%h required 00000005", d); end
        exp_q.delete();
        hold_z = 1'b0;
        b = $urandom_range(0, 1 << 20);
        bus_write(3'd1, to_f32(b));
        wait_res_count(1);
        bus_read(3'd2, d);
        checks++;
        if (d !== to_f32(last_a + b)) begin failures++; $display("FAIL clear_next_pair got=%h required %h", d, to_f32(last_a + b)); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        int unsigned e;
`ifdef RESULT_IRQ_EN
        bus_write(3'd5, 32'h2);
        bus_read(3'd5, d);
        checks++;
        if (d !== 32'h2) begin failures++; $display("FAIL irq_thresh_rd got=%h required 2", d); end
        push_pair($urandom_range(0, 1 << 20), $urandom_range(0, 1 << 20));
        wait_res_count(1);
        repeat (2) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_one_result got=%b required 0", irq); end
        push_pair($urandom_range(0, 1 << 20), $urandom_range(0, 1 << 20));
        wait_res_count(2);
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL irq_two_results got=%b required 1", irq); end
        bus_read(3'd2, d);
        e = exp_q.pop_front();
        checks++;
        if ({irq, d} !== {1'b1, to_f32(e)}) begin failures++; $display("FAIL irq_pop_edge got=%b/%h required 1/%h", irq, d, to_f32(e)); end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_deassert got=%b required 0", irq); end
        bus_write(3'd5, 32'h0);
`else
        bus_write(3'd5, 32'h2);
        bus_read(3'd5, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL irq_thresh_absent got=%h required 0", d); end
        push_pair($urandom_range(0, 1 << 20), $urandom_range(0, 1 << 20));
        push_pair($urandom_range(0, 1 << 20), $urandom_range(0, 1 << 20));
        wait_res_count(2);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_tied got=%b required 0", irq); end
        bus_read(3'd2, d);
        e = exp_q.pop_front();
        checks++;
        if (d !== to_f32(e)) begin failures++; $display("FAIL irq_result got=%h required %h", d, to_f32(e)); end
`endif
        while (exp_q.size() > 0) begin
            wait_res_count(1);
            bus_read(3'd2, d);
            e = exp_q.pop_front();
            checks++;
            if (d !== to_f32(e)) begin failures++; $display("FAIL irq_drain got=%h required %h", d, to_f32(e)); end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        int n;
        int unsigned b;
        hold_b = 1'b1;
        push_pair($urandom_range(1, 1 << 20), $urandom_range(0, 1 << 20));
        n = 0;
        while (core_b_stb !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        bus_read(3'd3, d);
        checks++;
        if (d[4] !== 1'b1) begin failures++; $display("FAIL areset_busy_before got=%b required 1", d[4]); end
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({av.readdata, av.waitrequest, irq} !== 34'd0) begin
            failures++; $display("FAIL areset_bus got=%h/%b/%b required 0/0/0", av.readdata, av.waitrequest, irq);
        end
        checks++;
        if ({core_a_stb, core_b_stb, core_z_ack, core_rst} !== 4'b0001) begin
            failures++; $display("FAIL areset_core got=%b required 0001", {core_a_stb, core_b_stb, core_z_ack, core_rst});
        end
        @(negedge clk);
        reset_n = 1'b1;
        hold_b = 1'b0;
        exp_q.delete();
        bus_read(3'd3, d);
        checks++;
        if (d !== 32'h0000_0005) begin failures++; $display("FAIL areset_status got=%h required 00000005", d); end
        b = $urandom_range(1, 1 << 20);
        bus_write(3'd1, to_f32(b));
        wait_res_count(1);
        bus_read(3'd2, d);
        checks++;
        if (d !== to_f32(b)) begin failures++; $display("FAIL areset_staging_zero got=%h required %h", d, to_f32(b)); end
    endtask

    initial begin
        av.address = '0; av.writedata = '0; av.write = 1'b0; av.read = 1'b0;
        test_reset();
        test_single_add();
        test_burst();
        test_random();
        test_back_to_back_stall();
        test_underflow_sticky();
        test_clear();
        test_irq();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
